// File: rtl/rasterizer_pkg.sv
// Shared types and constants for the rasterizer pixel writer.
// DEPTH_WRITE_EN selects whether depth travels through the FIFO and gets its own bus write.
package rasterizer_pkg;

    localparam int unsigned ADDR_W  = 26;
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned DEPTH_W = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned COUNT_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
        logic [DEPTH_W-1:0] depth;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_COLOR = 2'd1,
        WR_DEPTH = 2'd2
    } writer_state_t;

    localparam logic [BE_W-1:0] FULL_BYTEENABLE = 4'hF;

`ifdef DEPTH_WRITE_EN
    localparam int unsigned FIFO_W = ADDR_W + COLOR_W + DEPTH_W;
`else
    localparam int unsigned FIFO_W = ADDR_W + COLOR_W;
`endif

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed pixels.
module pixel_fifo #(
    parameter int unsigned WIDTH = 50,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/rasterizer_pixel_writer.sv
// Buffers z-tested pixels and writes colour (and depth when DEPTH_WRITE_EN is defined)
// to SDRAM through an Avalon-MM write master.
module rasterizer_pixel_writer
    import rasterizer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SKID       = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                input_valid,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [COLOR_W-1:0]  color_in,
    input  logic [DEPTH_W-1:0]  depth_in,
    input  logic [ADDR_W-1:0]   depth_offset,
    input  logic                flush_in,
    output logic                stall_out,
    output logic                done_out,
    output logic                busy,
    output logic                overflow,
    output logic [COUNT_W-1:0]  pixel_count,
    output logic [ADDR_W-1:0]   master_address,
    output logic                master_write,
    output logic                master_read,
    output logic [BE_W-1:0]     master_byteenable,
    output logic [DATA_W-1:0]   master_writedata,
    input  logic                master_waitrequest
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    writer_state_t      state_q, state_d;
    logic [FIFO_W-1:0]  hold_q, hold_d;
    logic [COUNT_W-1:0] pixel_count_q, pixel_count_d;
    logic               flush_pending_q, flush_pending_d;
    logic               overflow_q, overflow_d;

    logic [FIFO_W-1:0]  fifo_wdata, fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               push_c, pop_c, complete_c;
    logic [ADDR_W-1:0]  hold_addr;
    logic [COLOR_W-1:0] hold_color;

`ifdef DEPTH_WRITE_EN
    pixel_t in_px, hold_px;
    assign in_px      = '{addr: addr_in, color: color_in, depth: depth_in};
    assign fifo_wdata = in_px;
    assign hold_px    = pixel_t'(hold_q);
    assign hold_addr  = hold_px.addr;
    assign hold_color = hold_px.color;
`else
    logic unused_c;
    assign unused_c   = ^{depth_in, depth_offset};
    assign fifo_wdata = {addr_in, color_in};
    assign hold_addr  = hold_q[FIFO_W-1 -: ADDR_W];
    assign hold_color = hold_q[COLOR_W-1:0];
`endif

    pixel_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A full FIFO still accepts a pixel when the writer frees a slot in the same cycle.
    assign push_c = input_valid && (!fifo_full || pop_c);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!fifo_empty) state_d = WR_COLOR;
            WR_COLOR: begin
                if (!master_waitrequest) begin
`ifdef DEPTH_WRITE_EN
                    state_d = WR_DEPTH;
`else
                    state_d = fifo_empty ? IDLE : WR_COLOR;
`endif
                end
            end
`ifdef DEPTH_WRITE_EN
            WR_DEPTH: if (!master_waitrequest) state_d = fifo_empty ? IDLE : WR_COLOR;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        master_write      = 1'b0;
        master_address    = '0;
        master_writedata  = '0;
        master_byteenable = '0;
        complete_c        = 1'b0;
        pop_c             = 1'b0;
        unique case (state_q)
            IDLE: pop_c = !fifo_empty;
            WR_COLOR: begin
                master_write      = 1'b1;
                master_address    = hold_addr;
                master_writedata  = DATA_W'(hold_color);
                master_byteenable = FULL_BYTEENABLE;
`ifndef DEPTH_WRITE_EN
                complete_c        = !master_waitrequest;
`endif
            end
`ifdef DEPTH_WRITE_EN
            WR_DEPTH: begin
                master_write      = 1'b1;
                master_address    = hold_addr + depth_offset;
                master_writedata  = hold_px.depth;
                master_byteenable = FULL_BYTEENABLE;
                complete_c        = !master_waitrequest;
            end
`endif
            default: ;
        endcase
        // Back-to-back: the next pixel is taken in the cycle the current one completes.
        if (complete_c) pop_c = !fifo_empty;
    end

    assign done_out        = flush_pending_q && fifo_empty && (state_q == IDLE) && !push_c;
    assign hold_d          = pop_c ? fifo_rdata : hold_q;
    assign pixel_count_d   = pixel_count_q + COUNT_W'(complete_c);
    assign flush_pending_d = done_out ? 1'b0 : (flush_pending_q || flush_in);
    assign overflow_d      = overflow_q || (input_valid && !push_c);

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q          <= '0;
            pixel_count_q   <= '0;
            flush_pending_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            hold_q          <= hold_d;
            pixel_count_q   <= pixel_count_d;
            flush_pending_q <= flush_pending_d;
            overflow_q      <= overflow_d;
        end
    end

    assign stall_out   = (fifo_count >= CNT_W'(FIFO_DEPTH - SKID));
    assign busy        = (fifo_count != '0) || (state_q != IDLE);
    assign overflow    = overflow_q;
    assign pixel_count = pixel_count_q;
    assign master_read = 1'b0;

endmodule
